// File: rtl/ram2_ctrl.sv
// ram2_ctrl: instruction-fetch responder that owns the RAM2 SRAM pins.
// Serves combinational reads for the fetch stage and runs a SETUP / PULSE / HOLD
// write strobe for word stores coming from the MEM stage, stalling fetch meanwhile.
// Optional feature macro: RAM2_WR_PROTECT_EN (rejects stores below PROT_LIMIT).
module ram2_ctrl #(
    parameter int WR_CYCLES = 2
`ifdef RAM2_WR_PROTECT_EN
    ,
    parameter logic [15:0] PROT_LIMIT = 16'h4000
`endif
) (
    input  logic        pci_clk,
    input  logic        pci_rst,
    input  logic [15:0] fetch_addr,
    input  logic        fetch_oe_n,
    output logic [15:0] fetch_data,
    output logic        fetch_stall,
    input  logic        st_req,
    input  logic [15:0] st_addr,
    input  logic [15:0] st_data,
    output logic        st_done,
    output logic        st_err,
    output logic [17:0] ram2_addr,
    inout  wire  [15:0] ram2_data,
    output logic        ram2_en_n,
    output logic        ram2_oe_n,
    output logic        ram2_we_n
);

    localparam int CntW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WR_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, W_SETUP, W_PULSE, W_HOLD} state_t;

    state_t          state_q, state_d;
    logic [CntW-1:0] wcnt_q, wcnt_d;
    logic [15:0]     waddr_q, waddr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [15:0]     last_data_q, last_data_d;
    logic [15:0]     addr_sel;
    logic            bus_drive;
    logic            store_blocked;

`ifdef RAM2_WR_PROTECT_EN
    logic rej_q, rej_d;
    logic below_limit;

    assign below_limit   = (st_addr < PROT_LIMIT);
    // A rejected store is answered in the following cycle; the requester still
    // holds st_req then, so it must not be taken as a new store.
    assign store_blocked = rej_q;
`else
    assign store_blocked = 1'b0;
`endif

    // The SRAM bus is ours only while a write sequence is in flight.
    assign bus_drive = (state_q != IDLE);
    assign ram2_data = bus_drive ? wdata_q : 16'hzzzz;
    assign ram2_en_n = 1'b0;
    assign ram2_addr = {2'b00, addr_sel};

    // State, strobe counter, latched store word and last fetched word.
    always_ff @(posedge pci_clk or negedge pci_rst) begin
        if (!pci_rst) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            last_data_q <= '0;
`ifdef RAM2_WR_PROTECT_EN
            rej_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            last_data_q <= last_data_d;
`ifdef RAM2_WR_PROTECT_EN
            rej_q       <= rej_d;
`endif
        end
    end

    // Next-state and pin/handshake outputs; everything is held quiet while in reset.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        last_data_d = last_data_q;
        addr_sel    = 16'h0000;
        ram2_oe_n   = 1'b1;
        ram2_we_n   = 1'b1;
        fetch_data  = last_data_q;
        fetch_stall = 1'b0;
        st_done     = 1'b0;
        st_err      = 1'b0;
`ifdef RAM2_WR_PROTECT_EN
        rej_d       = 1'b0;
        if (rej_q) begin
            st_done = 1'b1;
            st_err  = 1'b1;
        end
`endif
        if (pci_rst) begin
            case (state_q)
                IDLE: begin
                    if (st_req && !store_blocked) begin
                        fetch_stall = 1'b1;
`ifdef RAM2_WR_PROTECT_EN
                        if (below_limit) begin
                            rej_d = 1'b1;
                        end else begin
                            waddr_d = st_addr;
                            wdata_d = st_data;
                            state_d = W_SETUP;
                        end
`else
                        waddr_d = st_addr;
                        wdata_d = st_data;
                        state_d = W_SETUP;
`endif
                    end else if (!fetch_oe_n) begin
                        addr_sel    = fetch_addr;
                        ram2_oe_n   = 1'b0;
                        fetch_data  = ram2_data;
                        last_data_d = ram2_data;
                    end
                end
                W_SETUP: begin
                    fetch_stall = 1'b1;
                    addr_sel    = waddr_q;
                    wcnt_d      = '0;
                    state_d     = W_PULSE;
                end
                W_PULSE: begin
                    fetch_stall = 1'b1;
                    addr_sel    = waddr_q;
                    ram2_we_n   = 1'b0;
                    if (wcnt_q == CntLast) begin
                        wcnt_d  = '0;
                        state_d = W_HOLD;
                    end else begin
                        wcnt_d  = wcnt_q + CntW'(1);
                    end
                end
                W_HOLD: begin
                    fetch_stall = 1'b1;
                    addr_sel    = waddr_q;
                    st_done     = 1'b1;
                    state_d     = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram2_ctrl.sv
// tb_ram2_ctrl: scoreboard bench for ram2_ctrl with an SRAM model on the RAM2 pins.
// The driver computes each cycle's expected outputs from a word-level memory model
// and queues them; a monitor on the falling edge pops and compares.
module tb_ram2_ctrl;

    localparam int WrCycles = 2;
`ifdef RAM2_WR_PROTECT_EN
    localparam bit ProtectOn = 1'b1;
`else
    localparam bit ProtectOn = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] fetchData;
        logic        stall;
        logic        oeN;
        logic        weN;
        logic        done;
        logic        err;
        logic        chkAddr;
        logic [17:0] addr;
        logic        chkBus;
        logic [15:0] bus;
    } expect_t;

    logic        pciClk = 1'b0;
    logic        pciRst;
    logic [15:0] fetchAddr;
    logic        fetchOeN;
    logic [15:0] fetchData;
    logic        fetchStall;
    logic        stReq;
    logic [15:0] stAddr;
    logic [15:0] stData;
    logic        stDone;
    logic        stErr;
    logic [17:0] ram2Addr;
    wire  [15:0] ram2Data;
    logic        ram2EnN;
    logic        ram2OeN;
    logic        ram2WeN;

    logic [15:0] sramMem [65536];
    logic [15:0] refMem  [65536];
    logic [15:0] lastRef;
    expect_t     expQ [$];
    int          errors = 0;
    int          checks = 0;
    int          cycle  = 0;

    ram2_ctrl #(.WR_CYCLES(WrCycles)) dut (
        .pci_clk     (pciClk),
        .pci_rst     (pciRst),
        .fetch_addr  (fetchAddr),
        .fetch_oe_n  (fetchOeN),
        .fetch_data  (fetchData),
        .fetch_stall (fetchStall),
        .st_req      (stReq),
        .st_addr     (stAddr),
        .st_data     (stData),
        .st_done     (stDone),
        .st_err      (stErr),
        .ram2_addr   (ram2Addr),
        .ram2_data   (ram2Data),
        .ram2_en_n   (ram2EnN),
        .ram2_oe_n   (ram2OeN),
        .ram2_we_n   (ram2WeN)
    );

    // 100 MHz-style free-running clock
    always #5 pciClk = ~pciClk;

    // Asynchronous SRAM read model: drives the bus while selected and output-enabled
    assign ram2Data = (!ram2EnN && !ram2OeN && ram2WeN) ? sramMem[ram2Addr[15:0]] : 16'hzzzz;

    // SRAM write: the word on the bus is stored at each edge the strobe is low
    always @(posedge pciClk) begin
        cycle <= cycle + 1;
        if (!ram2EnN && !ram2WeN) sramMem[ram2Addr[15:0]] <= ram2Data;
    end

    function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycle, act, exp);
        end
    endfunction

    function automatic expect_t baseExpect();
        expect_t e;
        e           = '0;
        e.fetchData = lastRef;
        e.oeN       = 1'b1;
        e.weN       = 1'b1;
        return e;
    endfunction

    // Drive one cycle of inputs just after the rising edge and queue what it should produce
    task automatic applyStimulus(input logic oeN, input logic [15:0] fAddr, input logic req,
                                 input logic [15:0] sAddr, input logic [15:0] sData, input expect_t e);
        @(posedge pciClk);
        #1;
        fetchOeN  = oeN;
        fetchAddr = fAddr;
        stReq     = req;
        stAddr    = sAddr;
        stData    = sData;
        expQ.push_back(e);
    endtask

    task automatic doRead(input logic [15:0] a);
        expect_t e;
        e           = baseExpect();
        e.fetchData = refMem[a];
        e.oeN       = 1'b0;
        e.chkAddr   = 1'b1;
        e.addr      = {2'b00, a};
        applyStimulus(1'b0, a, 1'b0, 16'($urandom), 16'($urandom), e);
        lastRef = refMem[a];
    endtask

    task automatic doIdle();
        applyStimulus(1'b1, 16'($urandom), 1'b0, 16'($urandom), 16'($urandom), baseExpect());
    endtask

    // A store occupies WrCycles+3 cycles: request, setup, strobe, hold (done)
    task automatic doStore(input logic [15:0] a, input logic [15:0] d, input bit collide);
        expect_t e;
        bit      rej;
        rej     = ProtectOn && (a < 16'h4000);
        e       = baseExpect();
        e.stall = 1'b1;
        applyStimulus(collide ? 1'b0 : 1'($urandom), a, 1'b1, a, d, e);
        if (rej) begin
            e      = baseExpect();
            e.done = 1'b1;
            e.err  = 1'b1;
            applyStimulus(1'b1, 16'($urandom), 1'b1, 16'($urandom), 16'($urandom), e);
        end else begin
            for (int k = 1; k <= WrCycles + 2; k++) begin
                e         = baseExpect();
                e.stall   = 1'b1;
                e.chkAddr = 1'b1;
                e.addr    = {2'b00, a};
                e.chkBus  = 1'b1;
                e.bus     = d;
                e.weN     = !(k >= 2 && k <= WrCycles + 1);
                e.done    = (k == WrCycles + 2);
                applyStimulus(1'($urandom), 16'($urandom), 1'b1, 16'($urandom), 16'($urandom), e);
            end
            refMem[a] = d;
        end
    endtask

    function automatic logic [15:0] poolAddr();
        logic [15:0] bases [3];
        bases[0] = 16'h0100;
        bases[1] = 16'h4000;
        bases[2] = 16'h8000;
        return bases[$urandom_range(0, 2)] | 16'($urandom_range(0, 7));
    endfunction

    // Monitor: one queued expectation per cycle, compared on the falling edge
    initial begin
        expect_t e;
        forever begin
            @(negedge pciClk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("fetch_data", 32'(fetchData), 32'(e.fetchData));
                checkOutput("fetch_stall", 32'(fetchStall), 32'(e.stall));
                checkOutput("ram2_oe_n", 32'(ram2OeN), 32'(e.oeN));
                checkOutput("ram2_we_n", 32'(ram2WeN), 32'(e.weN));
                checkOutput("ram2_en_n", 32'(ram2EnN), 32'(1'b0));
                checkOutput("st_done", 32'(stDone), 32'(e.done));
                checkOutput("st_err", 32'(stErr), 32'(e.err));
                if (e.chkAddr) checkOutput("ram2_addr", 32'(ram2Addr), 32'(e.addr));
                if (e.chkBus)  checkOutput("ram2_data", 32'(ram2Data), 32'(e.bus));
            end
        end
    end

    // Driver: reset, directed scenarios, aborted write, then randomized traffic
    initial begin
        expect_t e;
        logic [15:0] a;
        for (int i = 0; i < 65536; i++) begin
            sramMem[i] = 16'(i * 16'h9E37) ^ 16'h1234;
            refMem[i]  = 16'(i * 16'h9E37) ^ 16'h1234;
        end
        sramMem[16'h0010] = 16'h4A01;
        refMem[16'h0010]  = 16'h4A01;
        lastRef   = 16'h0000;
        pciRst    = 1'b0;
        fetchOeN  = 1'b0;
        fetchAddr = 16'h0010;
        stReq     = 1'b1;
        stAddr    = 16'h8000;
        stData    = 16'h1111;
        #12;
        checkOutput("reset ram2_oe_n", 32'(ram2OeN), 32'(1'b1));
        checkOutput("reset ram2_we_n", 32'(ram2WeN), 32'(1'b1));
        checkOutput("reset ram2_en_n", 32'(ram2EnN), 32'(1'b0));
        checkOutput("reset ram2_addr", 32'(ram2Addr), 32'(18'h0));
        checkOutput("reset fetch_data", 32'(fetchData), 32'(16'h0));
        checkOutput("reset fetch_stall", 32'(fetchStall), 32'(1'b0));
        checkOutput("reset st_done", 32'(stDone), 32'(1'b0));
        checkOutput("reset st_err", 32'(stErr), 32'(1'b0));
        @(posedge pciClk);
        #1;
        stReq    = 1'b0;
        fetchOeN = 1'b1;
        pciRst   = 1'b1;

        doRead(16'h0010);
        doIdle();
        doStore(16'h8000, 16'hBEEF, 1'b0);
        doRead(16'h8000);
        doStore(16'h8001, 16'hCAFE, 1'b1);
        doRead(16'h8001);
        doStore(16'h4002, 16'h1357, 1'b0);
        doStore(16'h4003, 16'h2468, 1'b0);
        doRead(16'h4002);
        doRead(16'h4003);
        doStore(16'h0100, 16'hDEAD, 1'b0);
        doIdle();
        doStore(16'h4000, 16'hA5A5, 1'b0);
        doRead(16'h0100);
        doRead(16'h4000);

        // Abort a write in the middle of its strobe with an asynchronous reset
        e       = baseExpect();
        e.stall = 1'b1;
        applyStimulus(1'b1, 16'h0000, 1'b1, 16'h8004, 16'h7777, e);
        e         = baseExpect();
        e.stall   = 1'b1;
        e.chkAddr = 1'b1;
        e.addr    = 18'h08004;
        e.chkBus  = 1'b1;
        e.bus     = 16'h7777;
        applyStimulus(1'b1, 16'h0000, 1'b1, 16'h8004, 16'h7777, e);
        @(posedge pciClk);
        #1;
        fetchOeN  = 1'b0;
        fetchAddr = 16'h8004;
        #2;
        pciRst = 1'b0;
        #1;
        checkOutput("abort ram2_we_n", 32'(ram2WeN), 32'(1'b1));
        checkOutput("abort ram2_oe_n", 32'(ram2OeN), 32'(1'b1));
        checkOutput("abort fetch_data", 32'(fetchData), 32'(16'h0));
        checkOutput("abort st_done", 32'(stDone), 32'(1'b0));
        checkOutput("abort fetch_stall", 32'(fetchStall), 32'(1'b0));
        @(posedge pciClk);
        #1;
        stReq    = 1'b0;
        fetchOeN = 1'b1;
        pciRst   = 1'b1;
        lastRef  = 16'h0000;
        doIdle();
        doRead(16'h8004);

        for (int n = 0; n < 400; n++) begin
            a = poolAddr();
            case ($urandom_range(0, 3))
                0, 1:    doRead(a);
                2:       doIdle();
                default: doStore(a, 16'($urandom), 1'($urandom));
            endcase
        end
        doIdle();

        for (int w = 0; w < 20 && expQ.size() > 0; w++) @(posedge pciClk);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
